// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller.
//   pipeState_e - controller FSM states
//   pipeCtl_t   - bundle of stage-register enables, flushes and PC redirect
//   REG_ZERO    - architectural zero register (never a real dependency)
package pipe_ctrl_pkg;

  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } pipeState_e;

  typedef struct packed {
    logic pcWe;
    logic ifidWe;
    logic idexWe;
    logic exmemWe;
    logic ifidFlush;
    logic idexFlush;
    logic exmemFlush;
    logic redirect;
  } pipeCtl_t;

  // Normal advance: every stage register loads, nothing is squashed.
  function automatic pipeCtl_t ctlDefault();
    pipeCtl_t c;
    c = '0;
    c.pcWe    = 1'b1;
    c.ifidWe  = 1'b1;
    c.idexWe  = 1'b1;
    c.exmemWe = 1'b1;
    return c;
  endfunction

  // Held in reset: nothing advances, every stage holds a bubble.
  function automatic pipeCtl_t ctlReset();
    pipeCtl_t c;
    c = '0;
    c.ifidFlush  = 1'b1;
    c.idexFlush  = 1'b1;
    c.exmemFlush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// pipe_ctrl_hazard: combinational load-use hazard detection.
//   Flags a load in ID/EX whose destination is read by the instruction in ID.
//   Ports: id_rs, id_rt, id_uses_rt (ID operands), idex_mem_read, idex_rt
//   (load in ID/EX), loadUse_c (hazard present this cycle).
module pipe_ctrl_hazard
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rt,
  output logic             loadUse_c
);

  logic rsHit;
  logic rtHit;

  // Writes to the zero register are discarded, so they never create a dependency.
  always_comb begin
    rsHit     = (idex_rt == id_rs);
    rtHit     = id_uses_rt && (idex_rt == id_rt);
    loadUse_c = idex_mem_read && (idex_rt != REG_W'(REG_ZERO)) && (rsHit || rtHit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline hazard controller.
//   Priority each cycle: mem_busy (freeze all) > taken branch/jump (redirect,
//   flush IF/ID, ID/EX, EX/MEM) > load-use (one-cycle stall with bubble).
//   Inputs : clk, rst_n, id_rs, id_rt, id_uses_rt, idex_mem_read, idex_rt,
//            exmem_branch, exmem_zf, exmem_jump, mem_busy, perf_clr
//   Outputs: pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush,
//            exmem_flush, redirect (combinational), stall_cycles (registered)
//   Config : define PIPE_CTRL_PERF_EN to build the saturating stall counter;
//            otherwise stall_cycles is tied to zero.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             exmem_branch,
  input  logic             exmem_zf,
  input  logic             exmem_jump,
  input  logic             mem_busy,
  input  logic             perf_clr,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             redirect,
  output logic [CNT_W-1:0] stall_cycles
);

  pipeState_e state;
  pipeState_e nextState;
  pipeCtl_t   ctl;
  logic       loadUse;
  logic       take;
  logic       doStall;

  pipe_ctrl_hazard #(.REG_W(REG_W)) uHazard (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .idex_mem_read(idex_mem_read),
    .idex_rt      (idex_rt),
    .loadUse_c    (loadUse)
  );

  // A redirect held off by mem_busy re-presents itself because EX/MEM is frozen.
  assign take = (exmem_branch && exmem_zf) || exmem_jump;

  // The instruction stalled last cycle must not stall again on the same load.
  assign doStall = loadUse && (state != LOAD_STALL);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= nextState;
  end

  // Next-state logic.
  always_comb begin
    nextState = RUN;
    if (mem_busy)     nextState = MEM_WAIT;
    else if (take)    nextState = RUN;
    else if (doStall) nextState = LOAD_STALL;
  end

  // Output logic; reset overrides everything so the pipe fills with bubbles.
  always_comb begin
    ctl = ctlDefault();
    if (!rst_n) begin
      ctl = ctlReset();
    end else if (mem_busy) begin
      ctl = '0;
    end else if (take) begin
      ctl.ifidFlush  = 1'b1;
      ctl.idexFlush  = 1'b1;
      ctl.exmemFlush = 1'b1;
      ctl.redirect   = 1'b1;
    end else if (doStall) begin
      ctl.pcWe      = 1'b0;
      ctl.ifidWe    = 1'b0;
      ctl.idexFlush = 1'b1;
    end
  end

  assign pc_we       = ctl.pcWe;
  assign ifid_we     = ctl.ifidWe;
  assign idex_we     = ctl.idexWe;
  assign exmem_we    = ctl.exmemWe;
  assign ifid_flush  = ctl.ifidFlush;
  assign idex_flush  = ctl.idexFlush;
  assign exmem_flush = ctl.exmemFlush;
  assign redirect    = ctl.redirect;

`ifdef PIPE_CTRL_PERF_EN
  // Saturating count of cycles in which the PC did not advance; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
    end else if (!ctl.pcWe && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
`else
  logic unusedPerfClr;
  assign unusedPerfClr = perf_clr;
  assign stall_cycles  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl. A driver applies one cycle of
// inputs and pushes the reference model's expected outputs; a monitor pops and
// compares on the falling edge. Build with PIPE_CTRL_PERF_EN to check the counter.
module tb_pipe_ctrl;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [REG_W-1:0] id_rs, id_rt, idex_rt;
  logic             id_uses_rt, idex_mem_read;
  logic             exmem_branch, exmem_zf, exmem_jump, mem_busy, perf_clr;
  logic             pc_we, ifid_we, idex_we, exmem_we;
  logic             ifid_flush, idex_flush, exmem_flush, redirect;
  logic [CNT_W-1:0] stall_cycles;

  typedef struct packed {
    logic [7:0]       ctl;  // pc,ifid,idex,exmem we; ifid,idex,exmem flush; redirect
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          cycle = 0;
  bit          stalledLast = 0;  // previous cycle already paid a load-use stall
  int unsigned modelCnt = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .exmem_branch(exmem_branch),
    .exmem_zf(exmem_zf), .exmem_jump(exmem_jump), .mem_busy(mem_busy), .perf_clr(perf_clr),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .redirect(redirect), .stall_cycles(stall_cycles)
  );

  // One cycle of stimulus plus its expected response.
  task automatic drive(input logic r, input logic busy, input logic br, input logic zf,
                       input logic jmp, input logic ld, input int lrt, input int rs,
                       input int rt, input logic usesRt, input logic clr);
    logic [7:0] e;
    bit         tk, lu, stallNow;
    exp_t       x;
    @(posedge clk);
    #1;
    rst_n = r; mem_busy = busy; exmem_branch = br; exmem_zf = zf; exmem_jump = jmp;
    idex_mem_read = ld; idex_rt = REG_W'(lrt); id_rs = REG_W'(rs); id_rt = REG_W'(rt);
    id_uses_rt = usesRt; perf_clr = clr;
    tk = (br && zf) || jmp;
    lu = ld && (lrt != 0) && ((lrt == rs) || (usesRt && (lrt == rt)));
    stallNow = 0;
    if (!r)                      e = 8'b0000_1110;
    else if (busy)               e = 8'b0000_0000;
    else if (tk)                 e = 8'b1111_1111;
    else if (lu && !stalledLast) begin e = 8'b0011_0100; stallNow = 1; end
    else                         e = 8'b1111_0000;
    if (!r) modelCnt = 0;
    x.ctl = e;
`ifdef PIPE_CTRL_PERF_EN
    x.cnt = CNT_W'(modelCnt);
`else
    x.cnt = '0;
`endif
    q.push_back(x);
    stalledLast = r && stallNow;
    if (!r || clr)                      modelCnt = 0;
    else if (!e[7] && modelCnt < CNT_MAX) modelCnt++;
    cycle++;
  endtask

  task automatic idle(input logic clr);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, clr);
  endtask

  // Monitor: compares every presented cycle against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t       x;
      logic [7:0] got;
      x   = q.pop_front();
      got = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, exmem_flush, redirect};
      total++;
      if (got !== x.ctl) begin
        bad++;
        $display("FAIL ctl cycle=%0d got=%b want=%b", cycle, got, x.ctl);
      end
      total++;
      if (stall_cycles !== x.cnt) begin
        bad++;
        $display("FAIL stall_cycles cycle=%0d got=%0d want=%0d", cycle, stall_cycles, x.cnt);
      end
    end
  end

  initial begin
    rst_n = 0; mem_busy = 0; exmem_branch = 0; exmem_zf = 0; exmem_jump = 0;
    idex_mem_read = 0; idex_rt = '0; id_rs = '0; id_rt = '0; id_uses_rt = 0; perf_clr = 0;

    // Reset state.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 1, 8, 8, 0, 0, 0);
    idle(1);
    // Load-use on rs: one stall, then persisting request ignored, then default.
    drive(1, 0, 0, 0, 0, 1, 8, 8, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 8, 8, 0, 0, 0);
    idle(0);
    // Load-use on rt only when rt is read.
    drive(1, 0, 0, 0, 0, 1, 5, 1, 5, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 5, 1, 5, 1, 0);
    idle(0);
    // Load to register zero never stalls.
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    // Taken branch beats load-use.
    drive(1, 0, 1, 1, 0, 1, 8, 8, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Jump held off by three busy cycles, taken on the fourth.
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(0);
    // Load-use stall, then busy, then load-use evaluated again out of MEM_WAIT.
    drive(1, 0, 0, 0, 0, 1, 3, 3, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 1, 3, 3, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 3, 3, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 3, 3, 0, 0, 0);
    // Counter saturation, then clear.
    for (int i = 0; i < 70; i++) drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0);
    // Reset during MEM_WAIT aborts it.
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 1, 2, 2, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset during LOAD_STALL aborts it; the pending load-use stalls afresh.
    drive(1, 0, 0, 0, 0, 1, 4, 4, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 4, 4, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 4, 4, 0, 0, 0);

    // Randomized traffic with small register space to make hazards frequent.
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 19) == 0);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
